incr_count_seq: RTL

//  Sequential stage wrapped around the 16-bit gate-level incrementor.
//  - Holds the count register and drives it onto the incrementor input (inc_a).
//  - Captures the incremented value (inc_s) on each enabled cycle.
//  - Runs a start/limit/done sequence, so a load value counts up to a limit.
//  - Serves as the PC/loop-counter stage for downstream control logic.

---
 rtl/incr_count_seq_pkg.sv | 14 +
 rtl/incr_count_seq_eq_cmp16.sv | 23 ++
 rtl/incr_count_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/incr_count_seq_pkg.sv
// Shared definitions for the incr_count_seq slice: count width, terminal value
// and the 2-bit sequencer state encoding.
package incr_count_seq_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/incr_count_seq_eq_cmp16.sv
// eq_cmp16: gate-level 16-bit equality comparator (xor per bit, or-reduce, invert).
module eq_cmp16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        eq
);

    logic [15:0] diff;
    logic        any_diff;

    genvar i;
    generate
        for (i = 0; i < 16; i = i + 1) begin : g_bit
            xor u_xor (diff[i], a[i], b[i]);
        end
    endgenerate

    or u_or (any_diff, diff[0], diff[1], diff[2], diff[3], diff[4], diff[5],
             diff[6], diff[7], diff[8], diff[9], diff[10], diff[11],
             diff[12], diff[13], diff[14], diff[15]);
    not u_not (eq, any_diff);

endmodule

// File: rtl/incr_count_seq.sv
// Count register and start/limit/done sequencer around an external incrementor.
// Optional build macro: COUNT_SATURATE_EN (count saturates at 16'hFFFF instead of wrapping).
module incr_count_seq
    import incr_count_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VAL    = 16'h0000,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] load_val,
    input  logic [15:0] limit,
    input  logic        en,
    input  logic [15:0] inc_s,
    output logic [15:0] inc_a,
    output logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        wrap
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count_nxt;
    logic [15:0] limit_q;
    logic [15:0] load_val_q;
    logic        wrap_nxt;
    logic        capture;
    logic        hit;
    logic        at_max;

    assign inc_a   = count;
    assign at_max  = (count == CNT_MAX);
    assign capture = (state == ST_IDLE) && start;

    eq_cmp16 u_eq (
        .a  (count),
        .b  (limit_q),
        .eq (hit)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    count_nxt = load_val;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (hit) begin
                        state_nxt = ST_DONE;
                    end else begin
`ifdef COUNT_SATURATE_EN
                        // Reaching the ceiling without hitting the limit ends the run.
                        if (at_max) begin
                            state_nxt = ST_DONE;
                        end else begin
                            count_nxt = inc_s;
                        end
`else
                        count_nxt = inc_s;
                        wrap_nxt  = at_max;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (AUTO_RESTART) begin
                    state_nxt = ST_RUN;
                    count_nxt = load_val_q;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= RESET_VAL;
            limit_q <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (capture) begin
                limit_q <= limit;
            end
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            wrap <= wrap_nxt;
        end
    end

    // Reload value is only consumed after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            load_val_q <= load_val;
        end
    end

endmodule
